imem_loader: RTL and testbench

- Boot-time writer for the instruction memory that the core fetches from.
- Accepts a framed byte stream on a valid/ready interface, normally from the UART receiver.
- Assembles little-endian 32-bit words and drives the memory's synchronous write port.
- Holds the CPU in reset until a complete, checksum-verified image has been written.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_word_packer.sv | 62 ++++++
 rtl/imem_loader.sv | 193 +++++++++++++++++++
 tb/tb_imem_loader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory boot loader: the loader FSM
// state encoding and the default frame start byte.
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

endpackage

// File: rtl/imem_word_packer.sv
// -----------------------------------------------------------------------------
// imem_word_packer
// Collects payload bytes into little-endian 32-bit words and keeps the running
// XOR checksum of every payload byte taken.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_clear       zero the running checksum (wins over i_take)
//   i_take        a payload byte is being accepted this cycle
//   i_lane        byte lane (0 = LSB) of the byte being taken
//   i_byte        payload byte
//   i_word_ready  lane-3 byte accepted: latch the completed word
//   o_word        last completed word, valid the cycle after i_word_ready
//   o_csum        XOR of all payload bytes taken since the last clear
// -----------------------------------------------------------------------------
module imem_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_take,
    input  logic [1:0]  i_lane,
    input  logic [7:0]  i_byte,
    input  logic        i_word_ready,
    output logic [31:0] o_word,
    output logic [7:0]  o_csum
);

    logic [23:0] r_low;
    logic [31:0] r_word;
    logic [7:0]  r_csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_low  <= '0;
            r_word <= '0;
            r_csum <= '0;
        end else begin
            if (i_take) begin
                case (i_lane)
                    2'd0:    r_low[7:0]   <= i_byte;
                    2'd1:    r_low[15:8]  <= i_byte;
                    2'd2:    r_low[23:16] <= i_byte;
                    default: ;
                endcase
            end
            // Lane 3 bypasses r_low so the full word is available the very
            // next cycle, lining up with the memory write strobe.
            if (i_word_ready) begin
                r_word <= {i_byte, r_low};
            end
            if (i_clear) begin
                r_csum <= '0;
            end else if (i_take) begin
                r_csum <= r_csum ^ i_byte;
            end
        end
    end

    assign o_word = r_word;
    assign o_csum = r_csum;

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Boot-time writer for the instruction memory. Parses a framed byte stream
// (MAGIC, count lo, count hi, 4*N payload bytes LSB first, XOR checksum),
// writes each assembled word to the memory's synchronous write port and keeps
// the core in reset until a full, checksum-verified image has been written.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_data      stream byte
//   in_valid     in_data valid
//   in_ready     loader can accept a byte (low only in DONE/ERR and in reset)
//   restart      one-cycle pulse, leaves DONE or ERR back to IDLE
//   mem_we       memory write enable, one cycle per word
//   mem_addr     word-aligned byte address
//   mem_wdata    word to write
//   cpu_rst_n    core reset, released only after a successful load
//   done         image loaded and verified
//   error        frame rejected
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned LENGTH = 1024,
    parameter int unsigned WIDTH  = 32,
    parameter logic [7:0]  MAGIC  = MAGIC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             restart,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             cpu_rst_n,
    output logic             done,
    output logic             error
);

    localparam int unsigned IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;

    state_t             r_state;
    logic [7:0]         r_cnt_lo;
    logic [IDX_W-1:0]   r_word_idx;
    logic [IDX_W-1:0]   r_last_idx;
    logic [1:0]         r_lane;
    logic               r_in_ready;
    logic               r_mem_we;
    logic [WIDTH-1:0]   r_mem_addr;
    logic               r_cpu_rst_n;
    logic               r_done;
    logic               r_error;

    logic               w_accept;
    logic [15:0]        w_count;
    logic               w_take;
    logic               w_word_ready;
    logic               w_clear;
    logic [31:0]        w_word;
    logic [7:0]         w_csum;
    logic [WIDTH-1:0]   w_addr;

    assign w_accept     = in_valid && r_in_ready;
    assign w_count      = {in_data, r_cnt_lo};
    assign w_take       = w_accept && (r_state == ST_DATA);
    assign w_word_ready = w_take && (r_lane == 2'd3);
    // Checksum restarts when a new payload begins and on every restart pulse.
    assign w_clear      = (w_accept && (r_state == ST_LEN1)) ||
                          (restart && ((r_state == ST_DONE) || (r_state == ST_ERR)));
    assign w_addr       = WIDTH'({r_word_idx, 2'b00});

    imem_word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_clear),
        .i_take       (w_take),
        .i_lane       (r_lane),
        .i_byte       (in_data),
        .i_word_ready (w_word_ready),
        .o_word       (w_word),
        .o_csum       (w_csum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt_lo    <= '0;
            r_word_idx  <= '0;
            r_last_idx  <= '0;
            r_lane      <= '0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_cpu_rst_n <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept && (in_data == MAGIC)) begin
                        r_state <= ST_LEN0;
                    end
                end
                ST_LEN0: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_cnt_lo <= in_data;
                        r_state  <= ST_LEN1;
                    end
                end
                ST_LEN1: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        if (32'(w_count) > LENGTH) begin
                            r_state    <= ST_ERR;
                            r_error    <= 1'b1;
                            r_in_ready <= 1'b0;
                        end else if (w_count == 16'd0) begin
                            r_state <= ST_CSUM;
                        end else begin
                            r_state    <= ST_DATA;
                            r_word_idx <= '0;
                            r_lane     <= '0;
                            // N <= LENGTH here, so N-1 fits the index width.
                            r_last_idx <= IDX_W'(w_count - 16'd1);
                        end
                    end
                end
                ST_DATA: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_lane <= r_lane + 2'd1;
                        if (r_lane == 2'd3) begin
                            r_mem_we   <= 1'b1;
                            r_mem_addr <= w_addr;
                            r_word_idx <= r_word_idx + IDX_W'(1);
                            if (r_word_idx == r_last_idx) begin
                                r_state <= ST_CSUM;
                            end
                        end
                    end
                end
                ST_CSUM: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (in_data == w_csum) begin
                            r_state     <= ST_DONE;
                            r_done      <= 1'b1;
                            r_cpu_rst_n <= 1'b1;
                        end else begin
                            r_state <= ST_ERR;
                            r_error <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (restart) begin
                        r_state     <= ST_IDLE;
                        r_done      <= 1'b0;
                        r_cpu_rst_n <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                ST_ERR: begin
                    r_cpu_rst_n <= 1'b0;
                    if (restart) begin
                        r_state    <= ST_IDLE;
                        r_error    <= 1'b0;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = WIDTH'(w_word);
    assign cpu_rst_n = r_cpu_rst_n;
    assign done      = r_done;
    assign error     = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader. Expected memory writes are queued when
// the byte completing each word is driven and are popped by a monitor when
// the loader pulses mem_we.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int unsigned LENGTH = 1024;
    localparam int unsigned WIDTH  = 32;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic [7:0]       in_data  = '0;
    logic             in_valid = 1'b0;
    logic             restart  = 1'b0;
    logic             in_ready;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             cpu_rst_n;
    logic             done;
    logic             error;

    always #5 clk = ~clk;

    imem_loader #(
        .LENGTH (LENGTH),
        .WIDTH  (WIDTH),
        .MAGIC  (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .restart   (restart),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .done      (done),
        .error     (error)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int          n_checks = 0;
    int          n_errors = 0;
    wr_t         exp_q[$];
    int          we_cyc[$];
    int          cyc      = 0;
    logic        prev_we  = 1'b0;
    int          stalls   = 0;
    logic [31:0] words[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_t e;
            we_cyc.push_back(cyc);
            check("we_not_consecutive", 32'(prev_we), 32'd0);
            check("write_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e.addr);
                check("wr_data", mem_wdata, e.data);
            end
        end
        prev_we <= mem_we;
    end

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
            stalls++;
        end
        if (n >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_after_reset", 32'(in_ready), 32'd1);
    endtask

    // Sends a full frame built from words[], queues the expected writes and
    // flips the checksum byte by csum_flip.
    task automatic send_frame(input logic [7:0] csum_flip, input bit gaps);
        logic [7:0]  x;
        logic [15:0] n;
        logic [31:0] w;
        wr_t         e;
        x = 8'h00;
        n = 16'(words.size());
        send_byte(8'hA5, gaps);
        send_byte(n[7:0], gaps);
        send_byte(n[15:8], gaps);
        for (int unsigned i = 0; i < words.size(); i++) begin
            w = words[i];
            for (int unsigned l = 0; l < 4; l++) begin
                if (l == 3) begin
                    e.addr = 32'(i * 4);
                    e.data = w;
                    exp_q.push_back(e);
                end
                x = x ^ w[8*l +: 8];
                send_byte(w[8*l +: 8], gaps);
            end
        end
        send_byte(x ^ csum_flip, gaps);
        in_valid = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("rst_done_clr", 32'(done), 32'd0);
        check("rst_error_clr", 32'(error), 32'd0);
        check("rst_cpu_held", 32'(cpu_rst_n), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic nominal_words();
        words.delete();
        words.push_back(32'h0000_0013);
        words.push_back(32'h0010_0093);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_t e;

        // Reset values
        #12;
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        check("reset_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_error", 32'(error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready();

        // Nominal load with idle gaps
        nominal_words();
        check("nom_cpu_before", 32'(cpu_rst_n), 32'd0);
        send_frame(8'h00, 1'b1);
        check("nom_done", 32'(done), 32'd1);
        check("nom_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        check("nom_error", 32'(error), 32'd0);
        check("nom_ready_low", 32'(in_ready), 32'd0);
        check("nom_writes_seen", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        check("nom_done_held", 32'(done), 32'd1);
        do_restart();

        // Bad checksum
        nominal_words();
        send_frame(8'h01, 1'b0);
        check("bad_error", 32'(error), 32'd1);
        check("bad_done", 32'(done), 32'd0);
        check("bad_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("bad_writes_seen", 32'(exp_q.size()), 32'd0);
        do_restart();

        // Oversize count LENGTH+1
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h04, 1'b0);
        in_valid = 1'b0;
        check("ovs_error", 32'(error), 32'd1);
        check("ovs_ready_low", 32'(in_ready), 32'd0);
        check("ovs_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        repeat (4) @(negedge clk);
        check("ovs_no_writes", 32'(we_cyc.size()), 32'd4);
        do_restart();

        // Noise then zero-length frame
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        check("zero_not_done_yet", 32'(done), 32'd0);
        send_byte(8'h00, 1'b0);
        in_valid = 1'b0;
        check("zero_done", 32'(done), 32'd1);
        check("zero_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        check("zero_no_writes", 32'(we_cyc.size()), 32'd4);
        do_restart();

        // Mid-frame asynchronous reset after 5 payload bytes
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        e.addr = 32'h0;
        e.data = 32'h0000_0013;
        exp_q.push_back(e);
        send_byte(8'h00, 1'b0);
        send_byte(8'h93, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_mem_we", 32'(mem_we), 32'd0);
        check("arst_mem_addr", mem_addr, 32'd0);
        check("arst_mem_wdata", mem_wdata, 32'd0);
        check("arst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_error", 32'(error), 32'd0);
        check("arst_writes_seen", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready();
        nominal_words();
        send_frame(8'h00, 1'b1);
        check("post_arst_done", 32'(done), 32'd1);
        check("post_arst_writes", 32'(exp_q.size()), 32'd0);
        do_restart();

        // Throughput: one byte per cycle
        we_cyc.delete();
        stalls = 0;
        nominal_words();
        send_frame(8'h00, 1'b0);
        check("tp_done", 32'(done), 32'd1);
        check("tp_no_stall", 32'(stalls), 32'd0);
        check("tp_we_count", 32'(we_cyc.size()), 32'd2);
        if (we_cyc.size() == 2) check("tp_we_spacing", 32'(we_cyc[1] - we_cyc[0]), 32'd4);
        do_restart();

        // Maximum image, LENGTH words of random data
        words.delete();
        for (int unsigned i = 0; i < LENGTH; i++) words.push_back($urandom);
        we_cyc.delete();
        send_frame(8'h00, 1'b0);
        check("max_done", 32'(done), 32'd1);
        check("max_we_count", 32'(we_cyc.size()), LENGTH);
        check("max_writes_seen", 32'(exp_q.size()), 32'd0);
        check("max_last_addr", mem_addr, 32'((LENGTH - 1) * 4));
        do_restart();

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
